// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, bubble encoding, stage state
// encoding, base-ISA opcode constants and register-field helpers.
package pipe_pkg;

   localparam int          XLEN         = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
   localparam int          FLUSH_CNT_W  = 3;              // holds FLUSH_CYCLES-1 for 1..7

   // RV32I major opcodes seen by the decode/execute boundary
   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } stage_state_e;

   function automatic logic [4:0] rs1_of(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [4:0] rs2_of(input logic [31:0] instr);
      return instr[24:20];
   endfunction

endpackage

// File: rtl/operand_sel.sv
// Operand forwarding mux: picks register-file or forwarded data per source
// and forces x0 reads to zero regardless of any forwarding request.
module operand_sel #(
   parameter int XLEN = 32
) (
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            hazard_a_i,
   input  logic            hazard_b_i,
   input  logic [XLEN-1:0] data_a_i,
   input  logic [XLEN-1:0] data_b_i,
   output logic [XLEN-1:0] op_a_o,
   output logic [XLEN-1:0] op_b_o
);

   // Select each operand, then let the x0 override win over forwarding.
   always_comb begin
      // NOTE: every output is given a default first so no path infers a latch.
      op_a_o = rs1_data_i;
      op_b_o = rs2_data_i;
      if (hazard_a_i) op_a_o = data_a_i;
      if (hazard_b_i) op_b_o = data_b_i;
      if (rs1_addr_i == 5'd0) op_a_o = '0;
      if (rs2_addr_i == 5'd0) op_b_o = '0;
   end

endmodule

// File: rtl/de_exe_stage.sv
// Decode-to-execute pipeline register with load-use hold and redirect flush.
// Optional build macro DE_EXE_PERF_EN adds saturating stall/flush counters.
module de_exe_stage #(
   parameter int          XLEN         = pipe_pkg::XLEN,
   parameter logic [31:0] NOP_INSTR    = pipe_pkg::NOP_INSTR,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr_de,
   input  logic [XLEN-1:0] pc_de,
   input  logic [XLEN-1:0] rs1_data_de,
   input  logic [XLEN-1:0] rs2_data_de,
   input  logic            stall,
   input  logic            hazard_a,
   input  logic            hazard_b,
   input  logic [XLEN-1:0] data_a_mgr,
   input  logic [XLEN-1:0] data_b_mgr,
   input  logic            redirect_exe,
   output logic [31:0]     instr_exe,
   output logic [XLEN-1:0] pc_exe,
   output logic [XLEN-1:0] op_a_exe,
   output logic [XLEN-1:0] op_b_exe,
   output logic            valid_exe,
   output logic            hold_fd
`ifdef DE_EXE_PERF_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);

   import pipe_pkg::*;

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   stage_state_e           state_q, state_d;
   logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   logic                   bubble;
   logic                   hold_c;

   logic [XLEN-1:0]        sel_a, sel_b;
   logic [31:0]            instr_q, instr_d;
   logic [XLEN-1:0]        pc_q, pc_d;
   logic [XLEN-1:0]        op_a_q, op_a_d;
   logic [XLEN-1:0]        op_b_q, op_b_d;
   logic                   valid_q, valid_d;

   operand_sel #(.XLEN(XLEN)) u_operand_sel (
      .rs1_addr_i (rs1_of(instr_de)),
      .rs2_addr_i (rs2_of(instr_de)),
      .rs1_data_i (rs1_data_de),
      .rs2_data_i (rs2_data_de),
      .hazard_a_i (hazard_a),
      .hazard_b_i (hazard_b),
      .data_a_i   (data_a_mgr),
      .data_b_i   (data_b_mgr),
      .op_a_o     (sel_a),
      .op_b_o     (sel_b)
   );

   // Next-state logic: redirect outranks stall; FLUSH ignores stall entirely.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bubble  = 1'b0;
      hold_c  = 1'b0;
      if (redirect_exe) begin
         bubble  = 1'b1;
         cnt_d   = FLUSH_RELOAD;
         state_d = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      end else begin
         unique case (state_q)
            ST_RUN, ST_HOLD: begin
               if (stall) begin
                  bubble  = 1'b1;
                  hold_c  = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FLUSH: begin
               bubble = 1'b1;
               cnt_d  = cnt_q - 1'b1;
               // leaving on the last bubble makes the total exactly FLUSH_CYCLES
               if (cnt_q <= 3'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Freeze request is combinational and always released while in reset.
   assign hold_fd = hold_c & ~rst;

   // Execute-slot contents: the decoded instruction or a bubble.
   always_comb begin
      instr_d = bubble ? NOP_INSTR : instr_de;
      pc_d    = bubble ? '0        : pc_de;
      op_a_d  = bubble ? '0        : sel_a;
      op_b_d  = bubble ? '0        : sel_b;
      valid_d = ~bubble;
   end

   // State and execute-slot registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge value of its sources, independent of block order.
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         valid_q <= valid_d;
      end
   end

   assign instr_exe = instr_q;
   assign pc_exe    = pc_q;
   assign op_a_exe  = op_a_q;
   assign op_b_exe  = op_b_q;
   assign valid_exe = valid_q;

`ifdef DE_EXE_PERF_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Saturating event counters for freeze cycles and redirects.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (hold_fd && (stall_cnt_q != '1))      stall_cnt_q <= stall_cnt_q + 1'b1;
         if (redirect_exe && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_de_exe_stage.sv
// Self-checking bench for de_exe_stage: directed scenarios followed by
// randomized traffic, compared against a countdown-based reference model.
module tb_de_exe_stage;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr_de, pc_de, rs1_data_de, rs2_data_de, data_a_mgr, data_b_mgr;
   logic        stall, hazard_a, hazard_b, redirect_exe;
   logic [31:0] instr_exe, pc_exe, op_a_exe, op_b_exe;
   logic        valid_exe, hold_fd;
`ifdef DE_EXE_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
   logic [31:0] m_stall_cnt, m_flush_cnt;
`endif

   // reference model state
   int          flush_left;
   logic [31:0] m_instr, m_pc, m_a, m_b;
   logic        m_valid;
   logic        last_hold;

   int n_pass  = 0;
   int n_total = 0;

   de_exe_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013), .FLUSH_CYCLES(FC)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_de     (instr_de),
      .pc_de        (pc_de),
      .rs1_data_de  (rs1_data_de),
      .rs2_data_de  (rs2_data_de),
      .stall        (stall),
      .hazard_a     (hazard_a),
      .hazard_b     (hazard_b),
      .data_a_mgr   (data_a_mgr),
      .data_b_mgr   (data_b_mgr),
      .redirect_exe (redirect_exe),
      .instr_exe    (instr_exe),
      .pc_exe       (pc_exe),
      .op_a_exe     (op_a_exe),
      .op_b_exe     (op_b_exe),
      .valid_exe    (valid_exe),
      .hold_fd      (hold_fd)
`ifdef DE_EXE_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   task automatic model_bubble();
      m_instr = 32'h0000_0013;
      m_pc    = 32'd0;
      m_a     = 32'd0;
      m_b     = 32'd0;
      m_valid = 1'b0;
   endtask

   // One clock: check the freeze request, advance the model, check the slot.
   task automatic run_cycle();
      logic exp_hold;
      #2;
      exp_hold = !rst && !redirect_exe && (flush_left == 0) && stall;
      check("hold_fd", {31'd0, hold_fd}, {31'd0, exp_hold});
      last_hold = exp_hold;
      if (rst) begin
         model_bubble();
         flush_left = 0;
      end else if (redirect_exe) begin
         model_bubble();
         flush_left = FC - 1;
      end else if (flush_left > 0) begin
         model_bubble();
         flush_left--;
      end else if (stall) begin
         model_bubble();
      end else begin
         m_instr = instr_de;
         m_pc    = pc_de;
         m_a     = (instr_de[19:15] == 5'd0) ? 32'd0 : (hazard_a ? data_a_mgr : rs1_data_de);
         m_b     = (instr_de[24:20] == 5'd0) ? 32'd0 : (hazard_b ? data_b_mgr : rs2_data_de);
         m_valid = 1'b1;
      end
`ifdef DE_EXE_PERF_EN
      if (rst) begin
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (exp_hold)     m_stall_cnt++;
         if (redirect_exe) m_flush_cnt++;
      end
`endif
      @(posedge clk);
      #1;
      check("instr_exe", instr_exe, m_instr);
      check("pc_exe",    pc_exe,    m_pc);
      check("op_a_exe",  op_a_exe,  m_a);
      check("op_b_exe",  op_b_exe,  m_b);
      check("valid_exe", {31'd0, valid_exe}, {31'd0, m_valid});
`ifdef DE_EXE_PERF_EN
      check("stall_cnt", stall_cnt, m_stall_cnt);
      check("flush_cnt", flush_cnt, m_flush_cnt);
`endif
   endtask

   task automatic rand_data();
      rs1_data_de = $urandom;
      rs2_data_de = $urandom;
      data_a_mgr  = $urandom;
      data_b_mgr  = $urandom;
   endtask

   initial begin
      flush_left = 0;
      last_hold  = 1'b0;
      model_bubble();
`ifdef DE_EXE_PERF_EN
      m_stall_cnt = 0;
      m_flush_cnt = 0;
`endif
      // reset held two cycles with busy inputs
      rst = 1'b1; stall = 1'b1; redirect_exe = 1'b0; hazard_a = 1'b1; hazard_b = 1'b1;
      instr_de = 32'h0020_81B3; pc_de = 32'h40; rand_data();
      run_cycle();
      stall = 1'b0; redirect_exe = 1'b1; pc_de = 32'h44; rand_data();
      run_cycle();
      check("rst_instr", instr_exe, 32'h0000_0013);
      check("rst_pc",    pc_exe,    32'd0);
      check("rst_valid", {31'd0, valid_exe}, 32'd0);

      // forwarding on operand A: add x3,x1,x2
      rst = 1'b0; redirect_exe = 1'b0; stall = 1'b0;
      instr_de = 32'h0020_81B3; pc_de = 32'h4;
      rs1_data_de = 32'd5; rs2_data_de = 32'd7; data_a_mgr = 32'd9; data_b_mgr = 32'd11;
      hazard_a = 1'b1; hazard_b = 1'b0;
      run_cycle();
      check("fwd_op_a",  op_a_exe, 32'd9);
      check("fwd_op_b",  op_b_exe, 32'd7);
      check("fwd_valid", {31'd0, valid_exe}, 32'd1);

      // x0 sources ignore forwarding
      instr_de = 32'h0020_01B3; pc_de = 32'h8; data_a_mgr = 32'hDEAD; hazard_a = 1'b1;
      run_cycle();
      check("x0_op_a", op_a_exe, 32'd0);
      instr_de = 32'h0000_81B3; pc_de = 32'hC; data_b_mgr = 32'hBEEF; hazard_b = 1'b1;
      run_cycle();
      check("x0_op_b", op_b_exe, 32'd0);

      // load-use stall for one cycle on pc 8
      hazard_a = 1'b0; hazard_b = 1'b0;
      instr_de = 32'h0031_0233; pc_de = 32'h8; stall = 1'b1; rand_data();
      run_cycle();
      check("lu_bubble_pc", pc_exe, 32'd0);
      stall = 1'b0;
      run_cycle();
      check("lu_issue_pc",    pc_exe, 32'h8);
      check("lu_issue_valid", {31'd0, valid_exe}, 32'd1);
      pc_de = 32'hC; rand_data();
      run_cycle();
      check("lu_no_dup_pc", pc_exe, 32'hC);

      // stall and redirect together: redirect wins, stall ignored during flush
      stall = 1'b1; redirect_exe = 1'b1; pc_de = 32'h100;
      run_cycle();
      check("rd_bubble1", pc_exe, 32'd0);
      redirect_exe = 1'b0; pc_de = 32'h104;
      run_cycle();
      check("rd_bubble2", pc_exe, 32'd0);
      stall = 1'b0; pc_de = 32'h200;
      run_cycle();
      check("rd_target_pc", pc_exe, 32'h200);

      // redirect inside FLUSH reloads the counter
      redirect_exe = 1'b1; pc_de = 32'h300;
      run_cycle();
      pc_de = 32'h304;
      run_cycle();
      redirect_exe = 1'b0; pc_de = 32'h308;
      run_cycle();
      check("reload_bubble", pc_exe, 32'd0);
      pc_de = 32'h30C;
      run_cycle();
      check("reload_issue", pc_exe, 32'h30C);

`ifdef DE_EXE_PERF_EN
      // 3 stall cycles plus 1 redirect from a clean reset
      rst = 1'b1; run_cycle(); rst = 1'b0;
      stall = 1'b1; pc_de = 32'h400;
      for (int i = 0; i < 3; i++) run_cycle();
      stall = 1'b0; run_cycle();
      redirect_exe = 1'b1; run_cycle(); redirect_exe = 1'b0;
      for (int i = 0; i < FC; i++) run_cycle();
      check("perf_stall3",  stall_cnt, 32'd3);
      check("perf_flush1",  flush_cnt, 32'd1);
      rst = 1'b1; run_cycle(); rst = 1'b0;
      check("perf_rst_stall", stall_cnt, 32'd0);
      check("perf_rst_flush", flush_cnt, 32'd0);
`endif

      // randomized traffic with a fetch model that honours hold_fd
      for (int i = 0; i < 400; i++) begin
         logic was_redirect;
         was_redirect = redirect_exe;
         if (was_redirect) begin
            pc_de    = {$urandom_range(1, 32'h3FFF), 2'b00};
            instr_de = $urandom;
         end else if (!last_hold) begin
            pc_de    = pc_de + 32'd4;
            instr_de = $urandom;
         end
         if ($urandom_range(0, 3) == 0) instr_de[19:15] = 5'd0;
         if ($urandom_range(0, 3) == 0) instr_de[24:20] = 5'd0;
         rand_data();
         hazard_a     = 1'($urandom_range(0, 1));
         hazard_b     = 1'($urandom_range(0, 1));
         stall        = ($urandom_range(0, 3) == 0);
         redirect_exe = ($urandom_range(0, 9) == 0);
         rst          = ($urandom_range(0, 49) == 0);
         run_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/de_exe_stage.md
Name: de_exe_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the hazard/forwarding manager.
- Each cycle it selects operand A/B as either register-file read data or forwarded data from the manager.
- It registers the instruction, PC and operands into the execute stage.
- On a load-use stall it inserts NOP bubbles and freezes fetch/decode; on a taken branch or jump it flushes for a fixed number of cycles.

Parameters:
- XLEN, 32, datapath width of PC and operands
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0)
- FLUSH_CYCLES, 2, number of bubble cycles issued after a redirect (1..7)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- instr_de  in  32  instruction in decode
- pc_de  in  XLEN  PC of instruction in decode
- rs1_data_de  in  XLEN  register-file read of instr_de[19:15]
- rs2_data_de  in  XLEN  register-file read of instr_de[24:20]
- stall  in  1  load-use stall request from the hazard manager
- hazard_a  in  1  use data_a_mgr in place of rs1_data_de
- hazard_b  in  1  use data_b_mgr in place of rs2_data_de
- data_a_mgr  in  XLEN  forwarded operand A
- data_b_mgr  in  XLEN  forwarded operand B
- redirect_exe  in  1  taken branch/jump resolved in execute
- instr_exe  out  32  instruction to execute
- pc_exe  out  XLEN  PC to execute; 0 marks a bubble
- op_a_exe  out  XLEN  operand A to execute
- op_b_exe  out  XLEN  operand B to execute
- valid_exe  out  1  execute slot holds a real instruction
- hold_fd  out  1  freeze fetch and decode registers this cycle

Behaviour:
- Reset (rst=1 at a clock edge):
  - instr_exe=NOP_INSTR, pc_exe=0, op_a_exe=0, op_b_exe=0, valid_exe=0.
  - State goes to RUN, flush counter cleared.
  - Reset during HOLD or FLUSH aborts it immediately.
  - hold_fd is 0 during reset.
- Operand select (combinational, before the register):
  - A = hazard_a ? data_a_mgr : rs1_data_de.
  - B = hazard_b ? data_b_mgr : rs2_data_de.
  - If instr_de[19:15]==0, A is forced to 0; if instr_de[24:20]==0, B is forced to 0. Forwarding is ignored for x0.
- Latency: one cycle from decode inputs to the *_exe outputs.
- Bubble load means: instr_exe=NOP_INSTR, pc_exe=0, op_a/op_b=0, valid_exe=0. pc_exe=0 is required so the manager suppresses execute-stage forwarding.
- States:
  - RUN, no stall, no redirect: load decode values; valid_exe=1.
  - RUN, stall=1, redirect_exe=0: load a bubble, go to HOLD; hold_fd=1 combinationally in this same cycle.
  - HOLD: hold_fd stays 1 while stall=1 and execute keeps receiving bubbles. When stall=0, load the held decode instruction (with current operand select), go to RUN, hold_fd=0.
  - Any state, redirect_exe=1: load a bubble, counter=FLUSH_CYCLES-1, go to FLUSH (or RUN if FLUSH_CYCLES==1); hold_fd=0.
  - FLUSH: load a bubble each cycle, decrement counter, go to RUN when counter==0. stall is ignored in FLUSH.
- Priority: rst > redirect_exe > stall.
  - Simultaneous stall and redirect: redirect wins, hold_fd=0.
  - A redirect arriving during FLUSH reloads the counter.
- A held instruction is never issued twice and never dropped unless a flush occurs.

Optional Feature:
- Macro DE_EXE_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle hold_fd=1; flush_cnt increments each redirect_exe=1 edge.
  - Both saturate at all ones and clear on rst.
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: NOP_INSTR constant, XLEN, stage state enum {RUN, HOLD, FLUSH}, opcode constants.
- One sub-module, operand_sel: pure combinational A/B forwarding mux with x0 forcing, reusable in other stages.
- FSM and pipeline register stay in de_exe_stage.

Test Plan:
- Reset: hold rst 2 cycles with inputs toggling -> instr_exe=32'h00000013, pc_exe=0, valid_exe=0, hold_fd=0.
- Forwarding: instr_de=add x3,x1,x2, rs1_data_de=5, data_a_mgr=9, hazard_a=1 -> next cycle op_a_exe=9, op_b_exe=rs2_data_de, valid_exe=1.
- x0 source: rs1=x0, hazard_a=1, data_a_mgr=32'hDEAD -> op_a_exe=0.
- Load-use: stall=1 for 1 cycle on pc_de=8 -> one bubble (pc_exe=0) and hold_fd=1 for that cycle, then pc_exe=8 valid; no duplicate issue.
- Redirect during stall: stall=1 and redirect_exe=1 same cycle -> hold_fd=0, FLUSH_CYCLES=2 bubbles, then the new pc_de issues.
- Perf (DE_EXE_PERF_EN): 3 stall cycles plus 1 redirect -> stall_cnt=3, flush_cnt=1; rst clears both.
